// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, response codes, wait-counter width and
// the completer FSM state encoding.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  // Wait counter holds 0..15 wait states
  localparam int CNT_W = 4;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b11
  } apb_state_e;

endpackage

// File: rtl/apb_regbank.sv
// DEPTH x 32-bit register bank with synchronous clear, per-byte write
// enables and a combinational read port.
//   clk      clock
//   rst      synchronous clear of every register
//   wr_en    commit wr_data into wr_idx on this edge
//   wr_idx   register index for the write
//   wr_strb  byte-lane enables for the write
//   wr_data  write data
//   rd_idx   register index for the read port
//   rd_data  contents of register rd_idx
module apb_regbank
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [APB_STRB_W-1:0] wr_strb,
  input  logic [APB_DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [APB_DATA_W-1:0] rd_data
);

  logic [APB_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_slave_regfile_ctrl.sv
// APB completer in front of a DEPTH x 32-bit register bank. Latches the
// setup-phase inputs, inserts WAIT_CYCLES wait states, decodes the latched
// address and answers with PREADY/PRDATA/PSLVERR.
//   PCLK     clock, rising edge
//   PRESET   synchronous active-high reset (also clears the register bank)
//   PSEL     completer select
//   PENABLE  access-phase marker
//   PWRITE   1 = write, 0 = read
//   PADDR    byte address
//   PWDATA   write data
//   PSTRB    byte-lane write enables
//   PREADY   transfer completes this cycle
//   PRDATA   read data, non-zero only on a successful read completion
//   PSLVERR  error response, only with PREADY
//
// state     | meaning
// ST_IDLE   | waiting for a setup phase; answers a missing setup with an error
// ST_ACCESS | access phase: counting wait states, then completing
module apb_slave_regfile_ctrl
  import apb_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_STRB_W-1:0] PSTRB,
  output logic                  PREADY,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]      WAIT_LOAD  = CNT_W'(WAIT_CYCLES);
  localparam logic [APB_ADDR_W-1:0] ADDR_LIMIT = APB_ADDR_W'(4 * DEPTH);

  apb_state_e state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [APB_ADDR_W-1:0] paddr_q;
  logic [APB_DATA_W-1:0] pwdata_q;
  logic [APB_STRB_W-1:0] pstrb_q;
  logic                  pwrite_q;

  logic                  latch_en;
  logic                  wr_en;
  logic                  addr_err;
  logic [IDX_W-1:0]      idx;
  logic [APB_DATA_W-1:0] rd_data;

  assign idx      = paddr_q[IDX_W+1:2];
  assign addr_err = (paddr_q[1:0] != 2'b00) || (paddr_q >= ADDR_LIMIT);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        paddr_q  <= PADDR;
        pwdata_q <= PWDATA;
        pstrb_q  <= PSTRB;
        pwrite_q <= PWRITE;
      end
    end
  end

  // Everything is held inactive while PRESET is high so a reset landing on a
  // completing access produces neither PREADY nor a write.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    wr_en    = 1'b0;
    PREADY   = 1'b0;
    PSLVERR  = RESP_OKAY;
    PRDATA   = '0;
    if (!PRESET) begin
      unique case (state_q)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            state_d  = ST_ACCESS;
            cnt_d    = WAIT_LOAD;
            latch_en = 1'b1;
          end else if (PSEL && PENABLE) begin
            // Access without a setup: complete with an error so the master
            // never hangs, but stay idle and touch nothing.
            PREADY  = 1'b1;
            PSLVERR = RESP_ERR;
          end
        end
        ST_ACCESS: begin
          if (PSEL && PENABLE) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else begin
              PREADY  = 1'b1;
              PSLVERR = addr_err ? RESP_ERR : RESP_OKAY;
              wr_en   = pwrite_q && !addr_err;
              if (!pwrite_q && !addr_err) begin
                PRDATA = rd_data;
              end
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  apb_regbank #(
    .DEPTH(DEPTH)
  ) u_regbank (
    .clk    (PCLK),
    .rst    (PRESET),
    .wr_en  (wr_en),
    .wr_idx (idx),
    .wr_strb(pstrb_q),
    .wr_data(pwdata_q),
    .rd_idx (idx),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_apb_slave_regfile_ctrl.sv
// Two completers share one APB bus behind separate select lines:
// dut0 with no wait states, dut1 with three.
module tb_apb_slave_regfile_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL0, PSEL1, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY0, PREADY1, PSLVERR0, PSLVERR1;
  logic [31:0] PRDATA0, PRDATA1;

  always #5 PCLK = ~PCLK;

  apb_slave_regfile_ctrl #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL0), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY0), .PRDATA(PRDATA0), .PSLVERR(PSLVERR0));

  apb_slave_regfile_ctrl #(.DEPTH(16), .WAIT_CYCLES(3)) dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL1), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY1), .PRDATA(PRDATA1), .PSLVERR(PSLVERR1));

  int          cur = 0;
  logic        rdy, slverr;
  logic [31:0] rdat;
  assign rdy    = (cur == 0) ? PREADY0  : PREADY1;
  assign slverr = (cur == 0) ? PSLVERR0 : PSLVERR1;
  assign rdat   = (cur == 0) ? PRDATA0  : PRDATA1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference register contents per completer
  logic [31:0] mdl [2][16];

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd64);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) mdl[d][i] = '0;
  endtask

  task automatic model_xfer(input int d, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st);
    if (wr && !exp_err(a)) begin
      for (int b = 0; b < 4; b++)
        if (st[b]) mdl[d][a / 4][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic set_sel(input int d, input logic v);
    if (d == 0) PSEL0 = v;
    else PSEL1 = v;
  endtask

  // Full transfer starting just after a rising edge; returns sampled
  // response and the cycle count from setup to completion.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic er, output int cycles);
    bit done;
    cur = d;
    PADDR = a; PWRITE = wr; PWDATA = wd; PSTRB = st; PENABLE = 1'b0;
    set_sel(d, 1'b1);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    // access-phase inputs must be ignored by the completer
    PADDR = $urandom; PWDATA = $urandom; PSTRB = 4'($urandom); PWRITE = 1'($urandom);
    cycles = 1; rd = '0; er = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge PCLK);
      cycles++;
      if (rdy) begin
        rd = rdat; er = slverr; done = 1'b1;
      end else if (cycles > 20) begin
        n_cmp++; n_bad++;
        $display("FAIL xfer_timeout: no PREADY after %0d cycles, required within %0d", cycles, 2 + wait_of(d));
        done = 1'b1;
      end
      @(posedge PCLK); #1;
    end
    set_sel(d, 1'b0);
    PENABLE = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, exp_rd;
    logic        er, e;
    int          cyc, d;
    logic        wr;
    logic [31:0] a, wd;
    logic [3:0]  st;
    time         t0;

    // Reset, with a would-be missing setup on dut0 that must stay silent
    PRESET = 1'b1; PSEL0 = 1'b1; PSEL1 = 1'b0; PENABLE = 1'b1; PWRITE = 1'b1;
    PADDR = 32'h4; PWDATA = '1; PSTRB = 4'hF;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_pready0", PREADY0, 0);
    chk("rst_pslverr0", PSLVERR0, 0);
    chk("rst_prdata0", PRDATA0, 0);
    chk("rst_pready1", PREADY1, 0);
    chk("rst_prdata1", PRDATA1, 0);
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL0 = 1'b0; PENABLE = 1'b0;
    model_clear();

    vt[0]  = '{0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2};
    vt[1]  = '{0, 1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2};
    vt[2]  = '{0, 1'b1, 32'h08, 32'h11223344, 4'hF, 32'h0,        1'b0, 2};
    vt[3]  = '{0, 1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 2};
    vt[4]  = '{0, 1'b0, 32'h08, 32'h0,        4'hF, 32'h11BB33DD, 1'b0, 2};
    vt[5]  = '{1, 1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        1'b0, 5};
    vt[6]  = '{0, 1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0,        1'b1, 2};
    vt[7]  = '{0, 1'b1, 32'h06, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1, 2};
    vt[8]  = '{0, 1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        1'b1, 2};
    vt[9]  = '{0, 1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2};
    vt[10] = '{0, 1'b1, 32'h3C, 32'h55AA55AA, 4'h0, 32'h0,        1'b0, 2};
    vt[11] = '{0, 1'b0, 32'h3C, 32'h0,        4'h0, 32'h0,        1'b0, 2};
    vt[12] = '{1, 1'b1, 32'h0C, 32'h0BADF00D, 4'hF, 32'h0,        1'b0, 5};
    vt[13] = '{1, 1'b0, 32'h0C, 32'h0,        4'h0, 32'h0BADF00D, 1'b0, 5};
    vt[14] = '{0, 1'b0, 32'h02, 32'h0,        4'h0, 32'h0,        1'b1, 2};

    for (int i = 0; i < 15; i++) begin
      xfer(vt[i].d, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, rd, er, cyc);
      chk($sformatf("vec%0d_prdata", i), rd, vt[i].rdata);
      chk($sformatf("vec%0d_pslverr", i), er, vt[i].err);
      chk($sformatf("vec%0d_cycles", i), cyc, vt[i].cyc);
      model_xfer(vt[i].d, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb);
    end

    // Master abort on dut1: PENABLE dropped during the wait states
    cur = 1;
    PADDR = 32'h0C; PWRITE = 1'b1; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
    PSEL1 = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge PCLK); chk("abort_wait_pready", rdy, 0);
      @(posedge PCLK); #1;
    end
    PENABLE = 1'b0;
    @(negedge PCLK); chk("abort_pready", rdy, 0);
    @(posedge PCLK); #1;
    PSEL1 = 1'b0;
    @(negedge PCLK); chk("abort_idle_pready", rdy, 0);
    @(posedge PCLK); #1;
    xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, cyc);
    chk("abort_reg_kept", rd, 32'h0BADF00D);

    // Missing setup on dut0: one-cycle error, nothing written
    cur = 0;
    PADDR = 32'h04; PWRITE = 1'b1; PWDATA = 32'h0; PSTRB = 4'hF;
    PSEL0 = 1'b1; PENABLE = 1'b1;
    @(negedge PCLK);
    chk("nosetup_pready", rdy, 1);
    chk("nosetup_pslverr", slverr, 1);
    chk("nosetup_prdata", rdat, 0);
    @(posedge PCLK); #1;
    PSEL0 = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK); chk("nosetup_after_pready", rdy, 0);
    @(posedge PCLK); #1;
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
    chk("nosetup_reg_kept", rd, 32'hDEADBEEF);

    // Randomized transfers against the reference model
    for (int i = 0; i < 60; i++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 127));
      else a = 32'($urandom_range(0, 15)) * 4;
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      e  = exp_err(a);
      exp_rd = (!wr && !e) ? mdl[d][a[5:2]] : 32'h0;
      xfer(d, wr, a, wd, st, rd, er, cyc);
      chk($sformatf("rnd%0d_prdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_pslverr", i), er, e);
      chk($sformatf("rnd%0d_cycles", i), cyc, 2 + wait_of(d));
      model_xfer(d, wr, a, wd, st);
    end

    // Reset landing on the completing access cycle of a dut0 write
    cur = 0;
    PADDR = 32'h10; PWRITE = 1'b1; PWDATA = 32'h12345678; PSTRB = 4'hF;
    PSEL0 = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(negedge PCLK);
    chk("rstacc_pready", rdy, 0);
    chk("rstacc_pslverr", slverr, 0);
    chk("rstacc_prdata", rdat, 0);
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL0 = 1'b0; PENABLE = 1'b0;
    model_clear();
    for (int dd = 0; dd < 2; dd++)
      for (int i = 0; i < 16; i++) begin
        xfer(dd, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd, er, cyc);
        chk($sformatf("cleared_d%0d_r%0d", dd, i), rd, 0);
      end

    // Back-to-back write then read, no idle cycle in between
    t0 = $time;
    xfer(0, 1'b1, 32'h10, 32'hA5A55A5A, 4'hF, rd, er, cyc);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    chk("b2b_cycles", int'(($time - t0) / 10), 4);
    chk("b2b_prdata", rd, 32'hA5A55A5A);
    chk("b2b_pslverr", er, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
